// File: rtl/shift_operand_stage.sv
// shift_operand_stage: two-entry skid buffer holding {X, Y, oor} operand
// pairs for a 32-bit logical right shifter. The head entry drives X_q/Y_q,
// and amt_oor flags shift amounts of 32 or more.
module shift_operand_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      X,
  input  logic [31:0]      Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      X_q,
  output logic [31:0]      Y_q,
  output logic             amt_oor,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t      state;
  logic [31:0] m_x, m_y, s_x, s_y;
  logic        m_oor, s_oor;
  logic        push, pop, in_oor;

  assign in_oor    = |Y[31:5];
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign X_q     = m_x;
  assign Y_q     = m_y;
  assign amt_oor = m_oor;

  // Occupancy FSM, entry storage, registered in_ready and transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      m_x      <= '0;
      m_y      <= '0;
      m_oor    <= 1'b0;
      s_x      <= '0;
      s_y      <= '0;
      s_oor    <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (pop) begin
        xfer_cnt <= xfer_cnt + 1'b1;
      end
      case (state)
        EMPTY: begin
          if (push) begin
            m_x   <= X;
            m_y   <= Y;
            m_oor <= in_oor;
            state <= ONE;
          end
          in_ready <= 1'b1;
        end
        ONE: begin
          // Simultaneous push and pop refills the head directly so a
          // streaming source sees no bubble.
          if (push && pop) begin
            m_x   <= X;
            m_y   <= Y;
            m_oor <= in_oor;
            in_ready <= 1'b1;
          end else if (push) begin
            s_x      <= X;
            s_y      <= Y;
            s_oor    <= in_oor;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (pop) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        TWO: begin
          if (pop) begin
            m_x      <= s_x;
            m_y      <= s_y;
            m_oor    <= s_oor;
            state    <= ONE;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_operand_stage.sv
// Scoreboard bench for shift_operand_stage: accepted operand pairs are
// queued with their expected shift results; a monitor checks every pop.
module tb_shift_operand_stage;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      X;
  logic [31:0]      Y;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      X_q;
  logic [31:0]      Y_q;
  logic             amt_oor;
  logic [CNT_W-1:0] xfer_cnt;

  shift_operand_stage #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X_q       (X_q),
    .Y_q       (Y_q),
    .amt_oor   (amt_oor),
    .xfer_cnt  (xfer_cnt)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } ent_t;

  ent_t             exp_q[$];
  logic [CNT_W-1:0] mcnt;
  int               tests;
  int               fails;
  int               pop_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Capture side: an offer seen with in_ready high is taken at the next edge
  always @(negedge clk) begin
    #1;
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back('{x: X, y: Y});
    end
  end

  // Monitor: occupancy, counter and head-entry checks; pops on out_ready
  always @(negedge clk) begin
    if (rst_n) begin
      ent_t        e;
      logic [31:0] dut_z;
      logic [31:0] exp_z;
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("xfer_cnt", xfer_cnt, mcnt);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e     = exp_q.pop_front();
        exp_z = e.x >> e.y;
        dut_z = amt_oor ? 32'h0 : (X_q >> Y_q[4:0]);
        chk("X_q", X_q, e.x);
        chk("Y_q", Y_q, e.y);
        chk("amt_oor", amt_oor, e.y >= 32);
        chk("shift_z", dut_z, exp_z);
        mcnt = mcnt + 1'b1;
        pop_count++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] x, input logic [31:0] y);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    X = x;
    Y = y;
    do begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    X = $urandom;
    Y = $urandom;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL offer_timeout: got no accept, expected accept within 50 cycles");
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_X_q", X_q, 32'h0);
    chk("rst_Y_q", Y_q, 32'h0);
    chk("rst_amt_oor", amt_oor, 1'b0);
    chk("rst_xfer_cnt", xfer_cnt, '0);
    exp_q.delete();
    mcnt = '0;
    in_valid = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int p0;
    tests     = 0;
    fails     = 0;
    pop_count = 0;
    mcnt      = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X         = '0;
    Y         = '0;
    #13;
    rst_n = 1'b1;
    step();

    // Reset from idle
    reset_pulse();

    // Single transfer
    out_ready = 1'b1;
    offer(32'hffffffff, 32'h00000010);
    repeat (3) step();

    // Backpressure and ordering
    out_ready = 1'b0;
    offer(32'haaaaaaaa, 32'h00000001);
    offer(32'hffffffff, 32'hffffffff);
    in_valid = 1'b1;
    X = 32'hffffffff;
    Y = 32'h000000ff;
    repeat (3) begin
      @(negedge clk);
      chk("bp_held_off", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    offer(32'hffffffff, 32'h000000ff);
    repeat (4) step();

    // Out-of-range boundaries
    offer(32'h00000000, 32'h7fffffff);
    offer(32'hffffffff, 32'h00000020);
    offer(32'hffffffff, 32'h0000001f);
    repeat (4) step();

    // Back-to-back streaming through the counter wrap
    p0 = pop_count;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      X = $urandom;
      Y = $urandom_range(0, 40);
      @(negedge clk);
      chk("stream_in_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("stream_pops", pop_count - p0, 20);
    step();
    repeat (2) step();

    // Reset while full
    out_ready = 1'b0;
    offer(32'h12345678, 32'h00000003);
    offer(32'h87654321, 32'h00000004);
    reset_pulse();
    out_ready = 1'b1;
    repeat (3) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 3) != 0;
      X         = $urandom;
      Y         = ($urandom % 2) ? ($urandom % 64) : $urandom;
      out_ready = ($urandom % 4) != 0;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_operand_stage.md
# shift_operand_stage

Registered operand stage that sits directly upstream of `shift_right_logical_32bit`. It accepts a 32-bit value `X` and a 32-bit shift amount `Y` over a valid/ready handshake and buffers them in a 2-entry skid buffer. Its registered outputs `X_q`/`Y_q` drive the shifter's `X`/`Y` inputs. It also pre-decodes an out-of-range shift amount (`Y >= 32`) so downstream logic can force a zero result without recomputing.

## Interface

Parameters:
- `CNT_W`, default 16: width of the transfer counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  upstream offers an operand pair.
- `in_ready`  out  1  stage can accept; registered.
- `X`  in  32  value to shift.
- `Y`  in  32  unsigned shift amount, full 32 bits.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  downstream consumes the head entry.
- `X_q`  out  32  head-entry value; feeds shifter `X`.
- `Y_q`  out  32  head-entry shift amount; feeds shifter `Y`.
- `amt_oor`  out  1  head entry has `Y_q[31:5] != 0`, i.e. logical result is all zeros.
- `xfer_cnt`  out  CNT_W  count of completed output transfers; wraps modulo 2^CNT_W.

## Operation

- Storage: main entry M (drives outputs) and skid entry S. Each entry holds `{X, Y, oor}`.
- `oor` is computed at capture as the OR of `Y[31:5]`. `Y` is never truncated; `Y = 32'hffffffff` is treated as unsigned 4294967295, giving `oor = 1`.
- push = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- States:
  - EMPTY: 0 entries.
  - ONE: M valid.
  - TWO: M and S valid.
- Transitions:
  - EMPTY, push → ONE; M <= input.
  - EMPTY, no push → EMPTY.
  - ONE, push & pop → ONE; M <= input.
  - ONE, push only → TWO; S <= input.
  - ONE, pop only → EMPTY.
  - ONE, neither → ONE.
  - TWO, pop → ONE; M <= S.
  - TWO, no pop → TWO. Push is impossible in TWO because `in_ready = 0`.
- Derived outputs:
  - `out_valid` = (state != EMPTY).
  - `in_ready` = next-state != TWO, registered.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- `X_q`/`Y_q`/`amt_oor` are M's fields. When EMPTY they hold the last value popped (stale, don't-care).
- `xfer_cnt` increments by 1 on every pop. `2^CNT_W - 1` wraps to 0.
- `in_valid` may deassert without a transfer. `out_ready` may toggle freely.
- X/Y on cycles without push are ignored.

## Timing

- Reset (async, takes effect immediately on `rst_n` low):
  - state = EMPTY.
  - `in_ready = 1`, `out_valid = 0`.
  - `X_q = 0`, `Y_q = 0`, `amt_oor = 0`, `xfer_cnt = 0`.
- Reset mid-operation discards all buffered entries. The first push after `rst_n` rises is accepted on the first clock edge.
- Latency: a push at edge N gives `out_valid = 1` with that data after edge N, i.e. the data is visible in cycle N+1.
- Throughput: 1 transfer/cycle with `out_ready` held high. No bubble on a simultaneous push and pop in ONE.
- Backpressure:
  - With `out_ready = 0` the stage absorbs exactly 2 entries.
  - `in_ready` falls the cycle after the second push.
  - `in_ready` rises the cycle after the first pop from TWO.
- Stability: while `out_valid & !out_ready`, `X_q`/`Y_q`/`amt_oor` are held bit-stable.
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- Downstream shifter output is combinational from `X_q`/`Y_q` and is valid in the same cycle as `out_valid`.

## Test plan

- Reset check: assert `rst_n = 0` mid-cycle. Required outputs immediately: `in_ready = 1`, `out_valid = 0`, `X_q = Y_q = 0`, `amt_oor = 0`, `xfer_cnt = 0`.
- Single transfer: push X=ffffffff, Y=00000010 with `out_ready = 1`. Required next cycle: `out_valid = 1`, `X_q = ffffffff`, `Y_q = 10`, `amt_oor = 0`, shifter Z = 0000ffff. After the pop, `xfer_cnt = 1`.
- Backpressure and order, with `out_ready = 0`:
  - Push (aaaaaaaa, 1), then (ffffffff, ffffffff). Required: `in_ready = 0`, and a third offer (ffffffff, ff) is held off.
  - Raise `out_ready`. Required pop order: (aaaaaaaa, 1, oor 0, Z = 55555555), then (ffffffff, ffffffff, oor 1), then (ffffffff, ff, oor 1).
- Out-of-range amounts: push (0, 7fffffff) and (ffffffff, 20). Required: `amt_oor = 1` for both. Push (ffffffff, 1f). Required: `amt_oor = 0`, Z = 00000001.
- Streaming and counter: set `xfer_cnt` preload to fffe via 65534 transfers, or use `CNT_W = 4` at 14. Stream 8 back-to-back pairs with `in_valid = out_ready = 1`. Required: 8 pops in 8 consecutive cycles, `in_ready` constantly 1, counter wraps through 0.
- Reset mid-operation: fill to TWO with `out_ready = 0`, then pulse `rst_n = 0` between edges. Required immediately: `out_valid = 0`, `in_ready = 1`. Neither old entry appears after reset release.
